// File: rtl/stack_cache_fill_sequencer.sv
// Fill sequencer for the 4-line stack cache.
// Purpose: owns the head/tail slot pointers, per-slot valid bits and per-slot
// line addresses. On a new stack pointer it reloads the cache with up to four
// line fetches. When the stack pointer steps into an adjacent line it refills
// the retiring tail slot. Only one fetch is outstanding at a time.
// Ports:
//   clk, async_rst          clock, asynchronous active-high reset
//   clk_en                  all registers hold while low
//   new_sp_valid/new_sp     new stack pointer write (pulse), prepop_en sampled with it
//   push_bound/pop_bound    legal line-base limits, sampled whenever a check runs
//   cross_valid/cross_push  adjacent-line crossing request, cross_ready = !stack_busy
//   slot_clean              per-slot clean status; a refill waits for it
//   fetch_req_*             line fetch request (valid/ready handshake)
//   fetch_resp_valid        pulse: requested line has been written into its slot
//   slot_valid, head, tail  cache bookkeeping outputs
//   stack_busy              registered, high while any sequence runs
module stack_cache_fill_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int LINE_SHIFT = 3
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic              clk_en,
    input  logic              new_sp_valid,
    input  logic [ADDR_W-1:0] new_sp,
    input  logic              prepop_en,
    input  logic [ADDR_W-1:0] push_bound,
    input  logic [ADDR_W-1:0] pop_bound,
    input  logic              cross_valid,
    input  logic              cross_push,
    output logic              cross_ready,
    input  logic [3:0]        slot_clean,
    output logic              fetch_req_valid,
    input  logic              fetch_req_ready,
    output logic [ADDR_W-1:0] fetch_req_addr,
    output logic [1:0]        fetch_req_slot,
    input  logic              fetch_resp_valid,
    output logic [3:0]        slot_valid,
    output logic [1:0]        head,
    output logic [1:0]        tail,
    output logic              stack_busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, DRAIN, WAIT_CLEAN} state_t;

    localparam int              LINE_BYTES = 1 << LINE_SHIFT;
    localparam logic [ADDR_W:0]   LINE1_W = (ADDR_W+1)'(LINE_BYTES);
    localparam logic [ADDR_W:0]   LINE2_W = (ADDR_W+1)'(2 * LINE_BYTES);
    localparam logic [ADDR_W-1:0] LINE1_A = ADDR_W'(LINE_BYTES);
    localparam logic [ADDR_W-1:0] LINE2_A = ADDR_W'(2 * LINE_BYTES);

    // One bit wider than the address so a carry lands above the bound and fails.
    function automatic logic up_ok(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] ofs,
                                   input logic [ADDR_W-1:0] bound);
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + ofs;
        return (sum <= {1'b0, bound});
    endfunction

    // A borrow sets the extra top bit and fails the check.
    function automatic logic dn_ok(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] ofs,
                                   input logic [ADDR_W-1:0] bound);
        logic [ADDR_W:0] diff;
        diff = {1'b0, base} - ofs;
        return !diff[ADDR_W] && (diff >= {1'b0, bound});
    endfunction

    state_t            state_reg, state_next;
    logic [1:0]        head_reg, head_next, tail_reg, tail_next;
    logic [1:0]        cur_slot_reg, cur_slot_next;
    logic [3:0]        slot_valid_reg, slot_valid_next;
    logic [3:0]        pend_reg, pend_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic              busy_reg;
    logic [ADDR_W-1:0] line_addr_reg [4];
    logic [ADDR_W-1:0] line_addr_next [4];
    logic [1:0]        ent_slot_reg [4];
    logic [1:0]        ent_slot_next [4];
    logic [ADDR_W-1:0] ent_addr_reg [4];
    logic [ADDR_W-1:0] ent_addr_next [4];

    // Fetch list for a new stack pointer, in issue order.
    logic [ADDR_W-1:0] sp_base;
    logic [3:0]        list_ok;
    logic [1:0]        list_slot [4];
    logic [ADDR_W-1:0] list_addr [4];

    always_comb begin
        sp_base = {new_sp[ADDR_W-1:LINE_SHIFT], {LINE_SHIFT{1'b0}}};
        list_ok = '0;
        if (prepop_en) begin
            list_slot[0] = 2'd2; list_addr[0] = sp_base + LINE2_A; list_ok[0] = up_ok(sp_base, LINE2_W, push_bound);
            list_slot[1] = 2'd3; list_addr[1] = sp_base + LINE1_A; list_ok[1] = up_ok(sp_base, LINE1_W, push_bound);
            list_slot[2] = 2'd0; list_addr[2] = sp_base;           list_ok[2] = 1'b1;
            list_slot[3] = 2'd1; list_addr[3] = sp_base - LINE1_A; list_ok[3] = dn_ok(sp_base, LINE1_W, pop_bound);
        end else begin
            list_slot[0] = 2'd3; list_addr[0] = sp_base + LINE1_A; list_ok[0] = up_ok(sp_base, LINE1_W, push_bound);
            list_slot[1] = 2'd0; list_addr[1] = sp_base;           list_ok[1] = 1'b1;
            list_slot[2] = 2'd1; list_addr[2] = sp_base - LINE1_A; list_ok[2] = dn_ok(sp_base, LINE1_W, pop_bound);
            list_slot[3] = 2'd2; list_addr[3] = sp_base - LINE2_A; list_ok[3] = dn_ok(sp_base, LINE2_W, pop_bound);
        end
    end

    // Crossing: new active base and the line the retiring tail should hold.
    logic [ADDR_W-1:0] cross_base, cross_tgt;
    logic              cross_ok, cross_hit;

    always_comb begin
        if (cross_push) begin
            cross_base = base_reg + LINE1_A;
            cross_tgt  = cross_base + LINE1_A;
            cross_ok   = up_ok(cross_base, LINE1_W, push_bound);
        end else begin
            cross_base = base_reg - LINE1_A;
            cross_tgt  = cross_base - LINE1_A;
            cross_ok   = dn_ok(cross_base, LINE1_W, pop_bound);
        end
        cross_hit = slot_valid_reg[tail_reg] && (line_addr_reg[tail_reg] == cross_tgt);
    end

    // Lowest pending list entry is the next to issue.
    logic [1:0] sel_idx;
    logic       sel_any;
    logic       req_fire;
    logic       outstanding;

    always_comb begin
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_reg[i]) sel_idx = 2'(i);
        end
    end

    assign sel_any         = |pend_reg;
    assign fetch_req_valid = (state_reg == ISSUE) && sel_any;
    assign fetch_req_addr  = ent_addr_reg[sel_idx];
    assign fetch_req_slot  = ent_slot_reg[sel_idx];
    assign req_fire        = fetch_req_valid && fetch_req_ready;
    // A response is still owed after this edge (unless it arrives this cycle).
    assign outstanding     = req_fire ||
                             (((state_reg == WAIT_RESP) || (state_reg == DRAIN)) && !fetch_resp_valid);

    always_comb begin
        state_next      = state_reg;
        head_next       = head_reg;
        tail_next       = tail_reg;
        base_next       = base_reg;
        cur_slot_next   = cur_slot_reg;
        slot_valid_next = slot_valid_reg;
        pend_next       = pend_reg;
        line_addr_next  = line_addr_reg;
        ent_slot_next   = ent_slot_reg;
        ent_addr_next   = ent_addr_reg;

        case (state_reg)
            IDLE: begin
                if (cross_valid) begin
                    base_next        = cross_base;
                    head_next        = cross_push ? head_reg - 2'd1 : head_reg + 2'd1;
                    tail_next        = cross_push ? tail_reg - 2'd1 : tail_reg + 2'd1;
                    pend_next        = '0;
                    ent_slot_next[0] = tail_reg;
                    ent_addr_next[0] = cross_tgt;
                    // Empty list in ISSUE gives exactly one busy cycle.
                    state_next       = ISSUE;
                    if (!cross_hit) begin
                        slot_valid_next[tail_reg] = 1'b0;
                        if (cross_ok) begin
                            pend_next  = 4'b0001;
                            state_next = WAIT_CLEAN;
                        end
                    end
                end
            end
            ISSUE: begin
                if (!sel_any) begin
                    state_next = IDLE;
                end else if (fetch_req_ready) begin
                    pend_next[sel_idx]             = 1'b0;
                    line_addr_next[fetch_req_slot] = fetch_req_addr;
                    cur_slot_next                  = fetch_req_slot;
                    state_next                     = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (fetch_resp_valid) begin
                    slot_valid_next[cur_slot_reg] = 1'b1;
                    state_next = sel_any ? ISSUE : IDLE;
                end
            end
            DRAIN: begin
                // The stale line is dropped; its slot was invalidated on relatch.
                if (fetch_resp_valid) state_next = ISSUE;
            end
            WAIT_CLEAN: begin
                if (slot_clean[ent_slot_reg[0]]) state_next = ISSUE;
            end
            default: state_next = IDLE;
        endcase

        // A new stack pointer overrides whatever the sequence was doing.
        if (new_sp_valid) begin
            base_next       = sp_base;
            head_next       = 2'd0;
            tail_next       = 2'd2;
            slot_valid_next = '0;
            pend_next       = list_ok;
            ent_slot_next   = list_slot;
            ent_addr_next   = list_addr;
            state_next      = outstanding ? DRAIN : ISSUE;
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_reg      <= IDLE;
            head_reg       <= 2'd0;
            tail_reg       <= 2'd2;
            base_reg       <= '0;
            cur_slot_reg   <= 2'd0;
            slot_valid_reg <= '0;
            pend_reg       <= '0;
            busy_reg       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                line_addr_reg[i] <= '0;
                ent_slot_reg[i]  <= '0;
                ent_addr_reg[i]  <= '0;
            end
        end else if (clk_en) begin
            state_reg      <= state_next;
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            base_reg       <= base_next;
            cur_slot_reg   <= cur_slot_next;
            slot_valid_reg <= slot_valid_next;
            pend_reg       <= pend_next;
            busy_reg       <= (state_next != IDLE);
            for (int i = 0; i < 4; i++) begin
                line_addr_reg[i] <= line_addr_next[i];
                ent_slot_reg[i]  <= ent_slot_next[i];
                ent_addr_reg[i]  <= ent_addr_next[i];
            end
        end
    end

    assign slot_valid  = slot_valid_reg;
    assign head        = head_reg;
    assign tail        = tail_reg;
    assign stack_busy  = busy_reg;
    assign cross_ready = !busy_reg;

endmodule

// File: tb/tb_stack_cache_fill_sequencer.sv
// Testbench for stack_cache_fill_sequencer: directed scenarios followed by
// randomized new-SP writes and crossings, compared against a line-level model.
module tb_stack_cache_fill_sequencer;
    logic        clk = 1'b0;
    logic        async_rst;
    logic        clk_en;
    logic        new_sp_valid;
    logic [15:0] new_sp;
    logic        prepop_en;
    logic [15:0] push_bound;
    logic [15:0] pop_bound;
    logic        cross_valid;
    logic        cross_push;
    logic        cross_ready;
    logic [3:0]  slot_clean;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [15:0] fetch_req_addr;
    logic [1:0]  fetch_req_slot;
    logic        fetch_resp_valid;
    logic [3:0]  slot_valid;
    logic [1:0]  head;
    logic [1:0]  tail;
    logic        stack_busy;

    always #5 clk = ~clk;

    stack_cache_fill_sequencer #(.ADDR_W(16), .LINE_SHIFT(3)) dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
        .new_sp_valid(new_sp_valid), .new_sp(new_sp), .prepop_en(prepop_en),
        .push_bound(push_bound), .pop_bound(pop_bound),
        .cross_valid(cross_valid), .cross_push(cross_push), .cross_ready(cross_ready),
        .slot_clean(slot_clean),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_req_addr(fetch_req_addr), .fetch_req_slot(fetch_req_slot),
        .fetch_resp_valid(fetch_resp_valid),
        .slot_valid(slot_valid), .head(head), .tail(tail), .stack_busy(stack_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line-level model: byte addresses as plain integers, slots as arrays.
    int m_head, m_tail, m_base;
    bit m_valid [4];
    int m_laddr [4];
    int exp_slot [$];
    int exp_addr [$];

    function automatic void model_reset();
        m_head = 0; m_tail = 2; m_base = 0;
        for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_laddr[i] = 0; end
        exp_slot.delete(); exp_addr.delete();
    endfunction

    function automatic void model_new_sp(input int sp, input bit pp, input int pb, input int qb);
        int b;
        b = (sp / 8) * 8;
        m_base = b; m_head = 0; m_tail = 2;
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        exp_slot.delete(); exp_addr.delete();
        if (pp && b + 16 <= pb) begin exp_slot.push_back(2); exp_addr.push_back(b + 16); end
        if (b + 8 <= pb)        begin exp_slot.push_back(3); exp_addr.push_back(b + 8); end
        exp_slot.push_back(0); exp_addr.push_back(b);
        if (b - 8 >= qb)        begin exp_slot.push_back(1); exp_addr.push_back(b - 8); end
        if (!pp && b - 16 >= qb) begin exp_slot.push_back(2); exp_addr.push_back(b - 16); end
    endfunction

    function automatic void model_cross(input bit push, input int pb, input int qb);
        int ot, tgt;
        bit ok;
        ot = m_tail;
        exp_slot.delete(); exp_addr.delete();
        if (push) begin
            m_base += 8; tgt = m_base + 8; ok = (tgt <= pb);
            m_head = (m_head + 3) % 4; m_tail = (m_tail + 3) % 4;
        end else begin
            m_base -= 8; tgt = m_base - 8; ok = (tgt >= qb);
            m_head = (m_head + 1) % 4; m_tail = (m_tail + 1) % 4;
        end
        if (!(m_valid[ot] && m_laddr[ot] == tgt)) begin
            m_valid[ot] = 0;
            if (ok) begin exp_slot.push_back(ot); exp_addr.push_back(tgt); end
        end
    endfunction

    function automatic logic [31:0] mvec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic int clip(input int v);
        if (v < 0) return 0;
        if (v > 65535) return 65535;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_new_sp(input int sp, input bit pp, input int pb, input int qb);
        new_sp = 16'(sp); prepop_en = pp; push_bound = 16'(pb); pop_bound = 16'(qb);
        new_sp_valid = 1'b1;
        tick();
        new_sp_valid = 1'b0;
        model_new_sp(sp, pp, pb, qb);
        $display("new_sp 0x%04h prepop=%0d push_bound=0x%04h pop_bound=0x%04h", sp, pp, pb, qb);
        check_val("newsp_busy", 32'(stack_busy), 1);
    endtask

    task automatic do_cross(input bit push, input int pb, input int qb);
        check_val("cross_ready", 32'(cross_ready), 1);
        push_bound = 16'(pb); pop_bound = 16'(qb); cross_push = push;
        cross_valid = 1'b1;
        tick();
        cross_valid = 1'b0;
        model_cross(push, pb, qb);
        $display("cross push=%0d push_bound=0x%04h pop_bound=0x%04h", push, pb, qb);
    endtask

    task automatic wait_req(input int eslot, input int eaddr, input int hold);
        int n;
        n = 0;
        while (!fetch_req_valid && n < 60) begin tick(); n++; end
        check_val("req_seen", 32'(fetch_req_valid), 1);
        if (fetch_req_valid) begin
            check_val("req_slot", 32'(fetch_req_slot), eslot);
            check_val("req_addr", 32'(fetch_req_addr), eaddr);
            $display("fetch slot=%0d addr=0x%04h", fetch_req_slot, fetch_req_addr);
            for (int i = 0; i < hold; i++) begin
                tick();
                check_val("hold_valid", 32'(fetch_req_valid), 1);
                check_val("hold_slot", 32'(fetch_req_slot), eslot);
                check_val("hold_addr", 32'(fetch_req_addr), eaddr);
            end
            fetch_req_ready = 1'b1;
            tick();
            fetch_req_ready = 1'b0;
            m_laddr[eslot] = eaddr;
            check_val("req_drop", 32'(fetch_req_valid), 0);
        end
    endtask

    task automatic respond(input int delay);
        for (int i = 0; i < delay; i++) tick();
        fetch_resp_valid = 1'b1;
        tick();
        fetch_resp_valid = 1'b0;
    endtask

    task automatic check_state();
        check_val("slot_valid", 32'(slot_valid), mvec());
        check_val("head", 32'(head), m_head);
        check_val("tail", 32'(tail), m_tail);
    endtask

    task automatic serve(input bit rnd);
        int s, a;
        if (exp_slot.size() == 0) begin
            check_val("busy_one", 32'(stack_busy), 1);
            tick();
            check_val("busy_drop", 32'(stack_busy), 0);
            check_val("no_req", 32'(fetch_req_valid), 0);
        end else begin
            while (exp_slot.size() > 0) begin
                s = exp_slot.pop_front();
                a = exp_addr.pop_front();
                wait_req(s, a, rnd ? int'($urandom_range(0, 3)) : 0);
                respond(rnd ? int'($urandom_range(0, 3)) : 0);
                m_valid[s] = 1;
            end
            check_val("busy_after_last", 32'(stack_busy), 0);
        end
        check_state();
    endtask

    task automatic rand_step();
        int sp, b, pb, qb, sel;
        bit dir, pp;
        if ($urandom_range(0, 2) != 0 && m_base >= 'h40 && m_base <= 'hFF00) begin
            pb  = clip(m_base + int'($urandom_range(0, 40)) - 8);
            qb  = clip(m_base - int'($urandom_range(0, 40)) + 8);
            dir = 1'($urandom_range(0, 1));
            slot_clean = 4'($urandom_range(0, 15));
            do_cross(dir, pb, qb);
            if (exp_slot.size() > 0) begin
                repeat ($urandom_range(0, 3)) tick();
            end
            slot_clean = 4'hF;
            serve(1'b1);
        end else begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      sp = int'($urandom_range(0, 31));
            else if (sel == 1) sp = int'($urandom_range('hFFE0, 'hFFFF));
            else               sp = int'($urandom_range(0, 'hFFFF));
            b  = (sp / 8) * 8;
            pb = clip(b + int'($urandom_range(0, 40)) - 8);
            qb = clip(b - int'($urandom_range(0, 40)) + 8);
            pp = 1'($urandom_range(0, 1));
            do_new_sp(sp, pp, pb, qb);
            serve(1'b1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        async_rst = 1'b1; clk_en = 1'b1; new_sp_valid = 1'b0; new_sp = '0; prepop_en = 1'b0;
        push_bound = '0; pop_bound = '0; cross_valid = 1'b0; cross_push = 1'b0;
        slot_clean = 4'hF; fetch_req_ready = 1'b0; fetch_resp_valid = 1'b0;
        model_reset();
        repeat (3) tick();
        async_rst = 1'b0;
        tick();

        // Reset state
        check_val("rst_busy", 32'(stack_busy), 0);
        check_val("rst_req", 32'(fetch_req_valid), 0);
        check_val("rst_ready", 32'(cross_ready), 1);
        check_state();

        // Full reload without prepop
        do_new_sp('h0104, 1'b0, 'h0200, 'h0000);
        serve(1'b0);
        check_val("t1_valid", 32'(slot_valid), 'hF);

        // Push crossing that has to wait for the tail to become clean
        slot_clean = 4'b1011;
        do_cross(1'b1, 'h0200, 'h0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("clean_wait_req", 32'(fetch_req_valid), 0);
            check_val("clean_wait_busy", 32'(stack_busy), 1);
        end
        slot_clean = 4'hF;
        serve(1'b0);
        check_val("t4_head", 32'(head), 3);
        check_val("t4_tail", 32'(tail), 1);

        // Prepop reload with a tight push bound, then crossings
        do_new_sp('h0100, 1'b1, 'h0108, 'h0000);
        serve(1'b0);
        check_val("t2_valid", 32'(slot_valid), 'b1011);
        do_cross(1'b0, 'h0108, 'h0000);
        serve(1'b0);
        do_cross(1'b1, 'h0108, 'h0000);
        serve(1'b0);
        do_cross(1'b1, 'h0108, 'h0000);
        serve(1'b0);

        // Stack pointer at zero: no pop-side wrap
        do_new_sp('h0000, 1'b0, 'h0200, 'h0000);
        check_val("t3_len", exp_slot.size(), 2);
        serve(1'b0);
        check_val("t3_valid", 32'(slot_valid), 'b1001);

        // New SP while a response is outstanding
        do_new_sp('h0400, 1'b0, 'h0800, 'h0000);
        wait_req(exp_slot.pop_front(), exp_addr.pop_front(), 3);
        do_new_sp('h0600, 1'b0, 'h0800, 'h0000);
        tick();
        check_val("drain_req", 32'(fetch_req_valid), 0);
        respond(1);
        check_val("drain_discard", 32'(slot_valid), 0);
        serve(1'b1);

        // Clock enable low: a new SP pulse is not taken
        clk_en = 1'b0;
        new_sp = 16'h1234; new_sp_valid = 1'b1;
        tick();
        new_sp_valid = 1'b0;
        tick();
        check_val("clken_busy", 32'(stack_busy), 0);
        check_state();
        clk_en = 1'b1;
        tick();

        // Randomized traffic
        for (int it = 0; it < 60; it++) rand_step();

        // Asynchronous reset in the middle of a sequence
        do_new_sp('h2000, 1'b0, 'h3000, 'h1000);
        #2;
        async_rst = 1'b1;
        #1;
        check_val("arst_busy", 32'(stack_busy), 0);
        check_val("arst_req", 32'(fetch_req_valid), 0);
        model_reset();
        check_state();
        tick();
        async_rst = 1'b0;
        respond(0);
        check_val("late_resp", 32'(slot_valid), 0);
        check_val("late_busy", 32'(stack_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
